// File: rtl/ttt_board_renderer.sv
// Two-stage tic-tac-toe pixel renderer behind the VGA timer; board/cursor snapshotted per frame.
// Optional macro TTT_CURSOR_BLINK_EN makes the cursor highlight blink every BLINK_FRAMES frames.
module ttt_board_renderer #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BOARD_X0     = 80,
  parameter int CELL         = 160,
  parameter int LINE_W       = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [17:0] board,
  input  logic [3:0]  cursor,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_done
);
  localparam int OW = $clog2(CELL);
  localparam int SW = OW + 2;
  localparam int R_IN  = CELL * 5 / 16;
  localparam int R_OUT = CELL * 29 / 80;
  localparam logic [16:0] D_MIN = 17'(R_IN * R_IN);
  localparam logic [16:0] D_MAX = 17'(R_OUT * R_OUT);

  logic          w_frame_evt;
  logic [9:0]    w_rx;
  logic [1:0]    w_col, w_row;
  logic [OW-1:0] w_xoff, w_yoff;
  logic          w_in_board;

  logic [1:0]    r_col, r_row;
  logic [OW-1:0] r_xoff, r_yoff;
  logic          r_in_board, r_von, r_hs1, r_vs1;
  logic [17:0]   r_snap_board;
  logic [3:0]    r_snap_cursor;
  logic          r_frame_done;
  logic [11:0]   r_rgb;
  logic          r_hs2, r_vs2;
  logic          w_phase;

  assign w_frame_evt = (vcount == 10'(V_ACTIVE)) && (hcount == 10'd0);
  assign w_rx        = hcount - 10'(BOARD_X0);
  assign w_in_board  = video_on && (hcount >= 10'(BOARD_X0)) &&
                       (hcount < 10'(BOARD_X0 + 3 * CELL)) && (vcount < 10'(3 * CELL));

  // Cell/offset split by range compares instead of a divider.
  always_comb begin
    w_col  = 2'd0;
    w_xoff = w_rx[OW-1:0];
    if (w_rx >= 10'(2 * CELL)) begin
      w_col  = 2'd2;
      w_xoff = OW'(w_rx - 10'(2 * CELL));
    end else if (w_rx >= 10'(CELL)) begin
      w_col  = 2'd1;
      w_xoff = OW'(w_rx - 10'(CELL));
    end
    w_row  = 2'd0;
    w_yoff = vcount[OW-1:0];
    if (vcount >= 10'(2 * CELL)) begin
      w_row  = 2'd2;
      w_yoff = OW'(vcount - 10'(2 * CELL));
    end else if (vcount >= 10'(CELL)) begin
      w_row  = 2'd1;
      w_yoff = OW'(vcount - 10'(CELL));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col <= '0; r_row <= '0; r_xoff <= '0; r_yoff <= '0;
      r_in_board <= 1'b0; r_von <= 1'b0; r_hs1 <= 1'b1; r_vs1 <= 1'b1;
      r_snap_board  <= '0;
      r_snap_cursor <= 4'd15;
      r_frame_done  <= 1'b0;
    end else begin
      r_col <= w_col; r_row <= w_row; r_xoff <= w_xoff; r_yoff <= w_yoff;
      r_in_board <= w_in_board; r_von <= video_on; r_hs1 <= hsync_in; r_vs1 <= vsync_in;
      r_frame_done <= w_frame_evt;
      if (w_frame_evt) begin
        r_snap_board  <= board;
        r_snap_cursor <= cursor;
      end
    end
  end

`ifdef TTT_CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (w_frame_evt) begin
      if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end
  assign w_phase = r_phase;
`else
  assign w_phase = 1'b1;
`endif

  logic [3:0]          w_cell_idx;
  logic [1:0]          w_cell_st;
  logic                w_grid, w_xmark, w_omark, w_xrange;
  logic signed [SW-1:0] w_dxy, w_sxy, w_adxy, w_asxy;
  logic signed [16:0]  w_ox, w_oy, w_ox2, w_oy2;
  logic [16:0]         w_d;
  logic [11:0]         w_rgb;

  assign w_cell_idx = {2'b00, r_row} * 4'd3 + {2'b00, r_col};
  assign w_cell_st  = r_snap_board[{w_cell_idx, 1'b0} +: 2];
  assign w_grid = (r_xoff < OW'(LINE_W / 2) && r_col != 2'd0) ||
                  (r_xoff >= OW'(CELL - LINE_W / 2) && r_col != 2'd2) ||
                  (r_yoff < OW'(LINE_W / 2) && r_row != 2'd0) ||
                  (r_yoff >= OW'(CELL - LINE_W / 2) && r_row != 2'd2);

  // X strokes: the two diagonals of the inset square, LINE_W thick either side.
  assign w_xrange = (r_xoff >= OW'(CELL / 10)) && (r_xoff < OW'(CELL - CELL / 10)) &&
                    (r_yoff >= OW'(CELL / 10)) && (r_yoff < OW'(CELL - CELL / 10));
  assign w_dxy  = $signed({2'b00, r_xoff}) - $signed({2'b00, r_yoff});
  assign w_sxy  = $signed({2'b00, r_xoff}) + $signed({2'b00, r_yoff}) - $signed(SW'(CELL - 1));
  assign w_adxy = w_dxy[SW-1] ? -w_dxy : w_dxy;
  assign w_asxy = w_sxy[SW-1] ? -w_sxy : w_sxy;
  assign w_xmark = (w_cell_st == 2'b01) && w_xrange &&
                   ((w_adxy < SW'(LINE_W)) || (w_asxy < SW'(LINE_W)));

  // O ring: squared distance from the cell centre against squared radii.
  assign w_ox  = $signed({9'd0, r_xoff}) - $signed(17'(CELL / 2));
  assign w_oy  = $signed({9'd0, r_yoff}) - $signed(17'(CELL / 2));
  assign w_ox2 = w_ox * w_ox;
  assign w_oy2 = w_oy * w_oy;
  assign w_d   = w_ox2 + w_oy2;
  assign w_omark = (w_cell_st == 2'b10) && (w_d >= D_MIN) && (w_d <= D_MAX);

  always_comb begin
    w_rgb = 12'h000;
    if (!r_von || !r_in_board)                      w_rgb = 12'h000;
    else if (w_grid)                                w_rgb = 12'hFFF;
    else if (w_xmark)                               w_rgb = 12'hF00;
    else if (w_omark)                               w_rgb = 12'h00F;
    else if (w_cell_idx == r_snap_cursor && w_phase) w_rgb = 12'h0A0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rgb <= 12'h000; r_hs2 <= 1'b1; r_vs2 <= 1'b1;
    end else begin
      r_rgb <= w_rgb; r_hs2 <= r_hs1; r_vs2 <= r_vs1;
    end
  end

  assign {red, green, blue} = r_rgb;
  assign hsync      = r_hs2;
  assign vsync      = r_vs2;
  assign frame_done = r_frame_done;
endmodule
